sprite_frame_mem: RTL and testbench

SPRITE_FRAME_MEM -- requirements
Module: sprite_frame_mem

---
 rtl/sprite_frame_mem_if.sv | 37 +++
 rtl/sprite_frame_mem.sv | 171 +++++++++++++++++
 tb/tb_sprite_frame_mem.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_frame_mem_if.sv
// -----------------------------------------------------------------------------
// sprite_frame_mem_if
// Avalon-MM CPU bus bundle for sprite_frame_mem.
//   address       word address {frame, word}
//   chipselect    request qualifier
//   read/write    transfer type
//   byteenable    byte lanes written on a write
//   writedata     write data
//   readdata      read data, valid with readdatavalid
//   readdatavalid read return strobe, one cycle after acceptance
//   waitrequest   stall; a request is accepted in a cycle where it is low
// Modports: master (CPU side), slave (memory side).
// -----------------------------------------------------------------------------
interface sprite_frame_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sprite_frame_mem.sv
// -----------------------------------------------------------------------------
// sprite_frame_mem
// Multi-frame sprite memory shared between a CPU (Avalon-MM slave) and a video
// fetch engine that streams a run of words from one frame into a pixel stream.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   bus               Avalon-MM slave (sprite_frame_mem_if.slave)
//   fetch_start       pulse, starts a fetch when idle
//   fetch_frame       frame to fetch from
//   fetch_addr        first word within the frame
//   fetch_len         number of words (0 = immediate fetch_done, no beats)
//   fetch_busy        high while a fetch is running or draining
//   fetch_done        one-cycle pulse when a fetch has fully drained
//   pix_data/valid    pixel stream output, transfer on pix_valid & pix_ready
//   pix_ready         pixel stream backpressure
//
// Build option: define SPRITE_FRAME_MEM_CPU_WRITE_EN to let CPU writes update
// the RAM. Without it, writes are accepted with the normal handshake but
// dropped, so the array becomes a ROM.
//
// The video side owns the single RAM port in any cycle it issues a read; a CPU
// request in that cycle is stalled with waitrequest. This also makes a pending
// video read win over a CPU write to the same word.
// -----------------------------------------------------------------------------
module sprite_frame_mem #(
  parameter int    DATA_W     = 16,
  parameter int    FRAME_AW   = 7,
  parameter int    NUM_FRAMES = 4,
  parameter string INIT_FILE  = "sprite.mif",
  localparam int   FB         = $clog2(NUM_FRAMES)
) (
  input  logic                clk,
  input  logic                reset,
  sprite_frame_mem_if.slave   bus,
  input  logic                fetch_start,
  input  logic [FB-1:0]       fetch_frame,
  input  logic [FRAME_AW-1:0] fetch_addr,
  input  logic [FRAME_AW:0]   fetch_len,
  output logic                fetch_busy,
  output logic                fetch_done,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_valid,
  input  logic                pix_ready
);

  localparam int AW     = FB + FRAME_AW;
  localparam int DEPTH  = NUM_FRAMES << FRAME_AW;
  localparam int NBYTES = DATA_W / 8;

`ifdef SPRITE_FRAME_MEM_CPU_WRITE_EN
  localparam bit CPU_WR_EN = 1'b1;
`else
  localparam bit CPU_WR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Initial contents are taken from INIT_FILE by the FPGA flow (MIF image).
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  state_t              state, state_nx;
  logic [FB-1:0]       frame_q;
  logic [FRAME_AW-1:0] addr_q;
  logic [FRAME_AW:0]   remain_q;

  logic [DATA_W-1:0]   fifo_mem [2];
  logic [1:0]          fifo_cnt;
  logic                fifo_rd_ptr, fifo_wr_ptr;

  logic [DATA_W-1:0]   ram_rdata_p1;
  logic                vid_vld_p1;
  logic                cpu_vld_p1;
  logic [DATA_W-1:0]   rd_hold;
  logic                done_q;

  logic                pop, start_acc, vid_rd, drain_end;
  logic                cpu_req, cpu_acc, cpu_rd, cpu_wr;
  logic [1:0]          occ_eff;
  logic [AW-1:0]       ram_addr;

  // ---- stage p0: request arbitration and address select ----
  assign pix_valid  = (fifo_cnt != 2'd0);
  assign pix_data   = fifo_mem[fifo_rd_ptr];
  assign pop        = pix_valid & pix_ready;

  // Occupancy after this cycle's pop plus the read still in flight; counting
  // the pop is what lets a held-high pix_ready see one beat per cycle.
  assign occ_eff    = fifo_cnt - {1'b0, pop} + {1'b0, vid_vld_p1};

  assign start_acc  = ~reset & fetch_start & (state == IDLE);
  assign vid_rd     = ~reset & (state == RUN) & (remain_q != '0) & (occ_eff < 2'd2);
  assign drain_end  = (state == DRAIN) & (fifo_cnt == 2'd0) & ~vid_vld_p1;

  assign cpu_req    = bus.chipselect & (bus.read | bus.write);
  assign bus.waitrequest = cpu_req & vid_rd;
  assign cpu_acc    = cpu_req & ~vid_rd & ~reset;
  assign cpu_rd     = cpu_acc & bus.read;
  assign cpu_wr     = cpu_acc & bus.write;

  assign ram_addr   = vid_rd ? {frame_q, addr_q} : bus.address;

  assign fetch_busy = (state != IDLE);
  assign fetch_done = done_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc && (fetch_len != '0)) state_nx = RUN;
      RUN:     if (vid_rd && (remain_q == (FRAME_AW+1)'(1))) state_nx = DRAIN;
      DRAIN:   if (drain_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vid_vld_p1  <= 1'b0;
      cpu_vld_p1  <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      done_q      <= 1'b0;
      rd_hold     <= '0;
    end else begin
      state       <= state_nx;
      vid_vld_p1  <= vid_rd;
      cpu_vld_p1  <= cpu_rd;
      fifo_cnt    <= fifo_cnt + {1'b0, vid_vld_p1} - {1'b0, pop};
      if (vid_vld_p1) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)        fifo_rd_ptr <= ~fifo_rd_ptr;
      done_q      <= drain_end | (start_acc & (fetch_len == '0));
      if (cpu_vld_p1) rd_hold <= ram_rdata_p1;
    end
  end

  // Fetch parameters; the word address wraps inside the latched frame.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      frame_q  <= fetch_frame;
      addr_q   <= fetch_addr;
      remain_q <= fetch_len;
    end else if (vid_rd) begin
      addr_q   <= addr_q + FRAME_AW'(1);
      remain_q <= remain_q - (FRAME_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (CPU_WR_EN && cpu_wr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.byteenable[b]) mem[ram_addr][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
    ram_rdata_p1 <= mem[ram_addr];
  end

  // ---- stage p1: RAM data routed to the CPU return or the pixel FIFO ----
  always_ff @(posedge clk) begin
    if (vid_vld_p1) fifo_mem[fifo_wr_ptr] <= ram_rdata_p1;
  end

  assign bus.readdatavalid = cpu_vld_p1;
  assign bus.readdata      = cpu_vld_p1 ? ram_rdata_p1 : rd_hold;

endmodule

// File: tb/tb_sprite_frame_mem.sv
module tb_sprite_frame_mem;
  localparam int DATA_W     = 16;
  localparam int FRAME_AW   = 7;
  localparam int NUM_FRAMES = 4;
  localparam int FB         = 2;
  localparam int AW         = FB + FRAME_AW;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                fetch_start = 1'b0;
  logic [FB-1:0]       fetch_frame = '0;
  logic [FRAME_AW-1:0] fetch_addr = '0;
  logic [FRAME_AW:0]   fetch_len = '0;
  logic                fetch_busy, fetch_done;
  logic [DATA_W-1:0]   pix_data;
  logic                pix_valid;
  logic                pix_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_frame_mem_if #(.DATA_W(DATA_W), .ADDR_W(AW)) bus ();

  sprite_frame_mem #(
    .DATA_W(DATA_W), .FRAME_AW(FRAME_AW), .NUM_FRAMES(NUM_FRAMES), .INIT_FILE("sprite.mif")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fetch_start(fetch_start), .fetch_frame(fetch_frame), .fetch_addr(fetch_addr),
    .fetch_len(fetch_len), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the INIT_FILE image: word i holds 0x5000 + i.
  function automatic logic [15:0] init_word(input int i);
    return 16'h5000 + 16'(i);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = '1;
    bus.address    = '0;
    bus.writedata  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    fetch_start = 1'b1; fetch_frame = 2'd1; fetch_addr = 7'd0; fetch_len = 8'd4;
    bus.chipselect = 1'b1; bus.read = 1'b1;
    #1;
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL reset_wait: got %0b expected 0", bus.waitrequest); else n_pass++;
    next_cycle();
    reset = 1'b0; fetch_start = 1'b0; bus_idle();
    #1;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", fetch_busy); else n_pass++;
    n_checks++; if (fetch_done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", fetch_done); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %0b expected 0", pix_valid); else n_pass++;
    n_checks++; if (bus.readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %0b expected 0", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== 16'h0000) $display("FAIL reset_readdata: got %h expected 0000", bus.readdata); else n_pass++;
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL reset_wait_after: got %0b expected 0", bus.waitrequest); else n_pass++;
    next_cycle();
    #1;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL start_in_reset_ignored: got busy %0b expected 0", fetch_busy); else n_pass++;
  endtask

  task automatic test_cpu_read();
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 9'h000;
    #1;
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL rd_wait: got %0b expected 0", bus.waitrequest); else n_pass++;
    next_cycle();
    bus.address = 9'h17F;
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b1) $display("FAIL rd0_valid: got %0b expected 1", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== 16'h5000) $display("FAIL rd0_data: got %h expected 5000", bus.readdata); else n_pass++;
    next_cycle();
    bus_idle();
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b1) $display("FAIL rd17f_valid: got %0b expected 1", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== 16'h517F) $display("FAIL rd17f_data: got %h expected 517f", bus.readdata); else n_pass++;
    next_cycle();
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b0) $display("FAIL rd_valid_drop: got %0b expected 0", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== 16'h517F) $display("FAIL rd_hold: got %h expected 517f", bus.readdata); else n_pass++;
  endtask

  task automatic test_byte_write();
    logic [15:0] exp_word;
`ifdef SPRITE_FRAME_MEM_CPU_WRITE_EN
    exp_word = 16'hAB85;
`else
    exp_word = 16'h5085;
`endif
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 9'h085;
    bus.byteenable = 2'b10; bus.writedata = 16'hABCD;
    #1;
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL wr_wait: got %0b expected 0", bus.waitrequest); else n_pass++;
    next_cycle();
    bus.write = 1'b0; bus.read = 1'b1; bus.byteenable = '1;
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b0) $display("FAIL wr_no_rdv: got %0b expected 0", bus.readdatavalid); else n_pass++;
    next_cycle();
    bus_idle();
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b1) $display("FAIL wr_readback_valid: got %0b expected 1", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== exp_word) $display("FAIL wr_readback_data: got %h expected %h", bus.readdata, exp_word); else n_pass++;
    next_cycle();
  endtask

  task automatic test_zero_len();
    fetch_start = 1'b1; fetch_frame = 2'd1; fetch_addr = 7'd3; fetch_len = 8'd0;
    next_cycle();
    fetch_start = 1'b0;
    #1;
    n_checks++; if (fetch_done !== 1'b1) $display("FAIL zero_len_done: got %0b expected 1", fetch_done); else n_pass++;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL zero_len_busy: got %0b expected 0", fetch_busy); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL zero_len_valid: got %0b expected 0", pix_valid); else n_pass++;
    next_cycle();
    #1;
    n_checks++; if (fetch_done !== 1'b0) $display("FAIL zero_len_done_pulse: got %0b expected 0", fetch_done); else n_pass++;
  endtask

  task automatic test_fetch_wrap();
    logic [15:0] exp_w [4];
    int beats, dones, first, last;
    exp_w[0] = 16'h517E; exp_w[1] = 16'h517F; exp_w[2] = 16'h5100; exp_w[3] = 16'h5101;
    beats = 0; dones = 0; first = -1; last = -1;
    pix_ready = 1'b1;
    fetch_start = 1'b1; fetch_frame = 2'd2; fetch_addr = 7'd126; fetch_len = 8'd4;
    next_cycle();
    fetch_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (fetch_done) dones++;
      if (pix_valid && pix_ready) begin
        if (beats < 4) begin
          n_checks++; if (pix_data !== exp_w[beats]) $display("FAIL wrap_beat%0d: got %h expected %h", beats, pix_data, exp_w[beats]); else n_pass++;
        end
        if (first < 0) first = c;
        last = c;
        beats++;
      end
      next_cycle();
    end
    n_checks++; if (beats !== 4) $display("FAIL wrap_beat_count: got %0d expected 4", beats); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL wrap_done_count: got %0d expected 1", dones); else n_pass++;
    n_checks++; if (last - first !== 3) $display("FAIL wrap_throughput: got span %0d expected 3", last - first); else n_pass++;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL wrap_busy_end: got %0b expected 0", fetch_busy); else n_pass++;
  endtask

  task automatic test_stall();
    int beats, dones;
    bit held;
    logic [15:0] held_data;
    beats = 0; dones = 0; held = 1'b0; held_data = '0;
    fetch_start = 1'b1; fetch_frame = 2'd1; fetch_addr = 7'd10; fetch_len = 8'd8;
    next_cycle();
    fetch_start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      pix_ready = (c % 3 == 0);
      if (c == 3) begin
        // Must be ignored: a fetch is already running.
        fetch_start = 1'b1; fetch_frame = 2'd0; fetch_addr = 7'd0; fetch_len = 8'd2;
      end else begin
        fetch_start = 1'b0;
      end
      #1;
      if (held) begin
        n_checks++; if ({pix_valid, pix_data} !== {1'b1, held_data}) $display("FAIL stall_hold: got %0b/%h expected 1/%h", pix_valid, pix_data, held_data); else n_pass++;
      end
      if (fetch_done) dones++;
      if (pix_valid && pix_ready) begin
        if (beats < 8) begin
          n_checks++; if (pix_data !== init_word(128 + 10 + beats)) $display("FAIL stall_beat%0d: got %h expected %h", beats, pix_data, init_word(128 + 10 + beats)); else n_pass++;
        end
        beats++;
        held = 1'b0;
      end else if (pix_valid) begin
        held = 1'b1;
        held_data = pix_data;
      end else begin
        held = 1'b0;
      end
      next_cycle();
    end
    pix_ready = 1'b1;
    n_checks++; if (beats !== 8) $display("FAIL stall_beat_count: got %0d expected 8", beats); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL stall_done_count: got %0d expected 1", dones); else n_pass++;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL stall_busy_end: got %0b expected 0", fetch_busy); else n_pass++;
  endtask

  task automatic test_cpu_stall();
    int waits, beats, dones;
    bit pending, expect_rdv;
    waits = 0; beats = 0; dones = 0; pending = 1'b1; expect_rdv = 1'b0;
    pix_ready = 1'b1;
    fetch_start = 1'b1; fetch_frame = 2'd3; fetch_addr = 7'd0; fetch_len = 8'd16;
    next_cycle();
    fetch_start = 1'b0;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 9'h0C3;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (expect_rdv) begin
        n_checks++; if ({bus.readdatavalid, bus.readdata} !== {1'b1, 16'h50C3}) $display("FAIL cpu_stall_read: got %0b/%h expected 1/50c3", bus.readdatavalid, bus.readdata); else n_pass++;
        expect_rdv = 1'b0;
      end
      if (pending) begin
        if (bus.waitrequest) waits++;
        else begin
          pending = 1'b0;
          expect_rdv = 1'b1;
        end
      end
      if (fetch_done) dones++;
      if (pix_valid && pix_ready) begin
        if (beats < 16) begin
          n_checks++; if (pix_data !== init_word(384 + beats)) $display("FAIL cpu_stall_beat%0d: got %h expected %h", beats, pix_data, init_word(384 + beats)); else n_pass++;
        end
        beats++;
      end
      next_cycle();
      if (!pending) bus_idle();
    end
    bus_idle();
    n_checks++; if (waits !== 16) $display("FAIL cpu_stall_waits: got %0d expected 16", waits); else n_pass++;
    n_checks++; if (beats !== 16) $display("FAIL cpu_stall_beat_count: got %0d expected 16", beats); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL cpu_stall_done_count: got %0d expected 1", dones); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int beats, dones, valids;
    beats = 0; dones = 0; valids = 0;
    pix_ready = 1'b1;
    fetch_start = 1'b1; fetch_frame = 2'd0; fetch_addr = 7'd20; fetch_len = 8'd10;
    next_cycle();
    fetch_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (pix_valid && pix_ready) begin
        n_checks++; if (pix_data !== init_word(20 + beats)) $display("FAIL abort_beat%0d: got %h expected %h", beats, pix_data, init_word(20 + beats)); else n_pass++;
        beats++;
      end
      if (beats == 2) break;
      next_cycle();
    end
    next_cycle();
    reset = 1'b1;
    #1;
    n_checks++; if ({pix_valid, pix_data} !== {1'b1, 16'h5016}) $display("FAIL abort_third_beat: got %0b/%h expected 1/5016", pix_valid, pix_data); else n_pass++;
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL abort_pix_valid: got %0b expected 0", pix_valid); else n_pass++;
    n_checks++; if (fetch_busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", fetch_busy); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (fetch_done) dones++;
      if (pix_valid) valids++;
      next_cycle();
    end
    n_checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else n_pass++;
    n_checks++; if (valids !== 0) $display("FAIL abort_no_beats: got %0d expected 0", valids); else n_pass++;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 9'h014;
    next_cycle();
    bus_idle();
    #1;
    n_checks++; if ({bus.readdatavalid, bus.readdata} !== {1'b1, 16'h5014}) $display("FAIL abort_ram_kept: got %0b/%h expected 1/5014", bus.readdatavalid, bus.readdata); else n_pass++;
    next_cycle();
    beats = 0; dones = 0;
    fetch_start = 1'b1; fetch_frame = 2'd0; fetch_addr = 7'd5; fetch_len = 8'd1;
    next_cycle();
    fetch_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fetch_done) dones++;
      if (pix_valid && pix_ready) begin
        n_checks++; if (pix_data !== 16'h5005) $display("FAIL restart_beat: got %h expected 5005", pix_data); else n_pass++;
        beats++;
      end
      next_cycle();
    end
    n_checks++; if (beats !== 1) $display("FAIL restart_beat_count: got %0d expected 1", beats); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL restart_done_count: got %0d expected 1", dones); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_FRAMES * (1 << FRAME_AW); i++) dut.mem[i] = init_word(i);
    bus_idle();
    test_reset();
    test_cpu_read();
    test_byte_write();
    test_zero_len();
    test_fetch_wrap();
    test_stall();
    test_cpu_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
